clip_control_input: RTL and testbench

- User-input front end for the two-clip audio recorder.
- Synchronises and debounces the record, play and clip-select pushbuttons, then runs the record/play mode state machine.
- Drives the `record`, `recordNum`, `play` and `clipPlayNum` signals consumed by the seven-segment LED interface and the audio datapath.
- Tracks which clip slots hold a recording and enforces a maximum record length.

---
 rtl/clip_control_input.sv | 155 +++++++++++++++
 tb/tb_clip_control_input.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/clip_control_input.sv
// Pushbutton front end for the two-clip recorder: synchronise, debounce and
// edge-detect record/play/clip buttons, then run the IDLE/RECORD/PLAY mode FSM.
module clip_control_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MAX_REC_CYCLES  = 50000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_record,
  input  logic       btn_play,
  input  logic       btn_clip,
  input  logic       clip_done,
  output logic       record,
  output logic       recordNum,
  output logic       play,
  output logic       clipPlayNum,
  output logic       clip_sel,
  output logic [1:0] clip_valid
);

  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned RCW = (MAX_REC_CYCLES > 1) ? $clog2(MAX_REC_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(MAX_REC_CYCLES - 1);

  // Button lanes: bit 0 = record, bit 1 = play, bit 2 = clip
  localparam int unsigned B_REC  = 0;
  localparam int unsigned B_PLAY = 1;
  localparam int unsigned B_CLIP = 2;

  typedef enum logic [1:0] {
    IDLE,
    RECORD,
    PLAY
  } state_t;

  logic [2:0]     btn_raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     db_q, db_d;
  logic [2:0]     dbp_q;
  logic [2:0]     press_q, press_d;
  logic [DBW-1:0] cnt_q [3];
  logic [DBW-1:0] cnt_d [3];

  state_t         state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic           record_q, record_d;
  logic           play_q, play_d;
  logic           rnum_q, rnum_d;
  logic           pnum_q, pnum_d;
  logic           sel_q, sel_d;
  logic [1:0]     valid_q, valid_d;

  assign btn_raw = {btn_clip, btn_play, btn_record};

  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d = db_q & ~dbp_q;
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rnum_d  = rnum_q;
    pnum_d  = pnum_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        // Mode decision uses the pre-toggle selection when clip coincides
        if (press_q[B_CLIP]) begin
          sel_d = ~sel_q;
        end
        if (press_q[B_REC]) begin
          state_d = RECORD;
          rnum_d  = sel_q;
          rcnt_d  = '0;
        end else if (press_q[B_PLAY] && valid_q[sel_q]) begin
          state_d = PLAY;
          pnum_d  = sel_q;
        end
      end
      RECORD: begin
        if (press_q[B_REC] || (rcnt_q == RC_LAST)) begin
          state_d         = IDLE;
          valid_d[rnum_q] = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      PLAY: begin
        if (press_q[B_PLAY] || clip_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    record_d = (state_d == RECORD);
    play_d   = (state_d == PLAY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      dbp_q    <= '0;
      press_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
      state_q  <= IDLE;
      rcnt_q   <= '0;
      record_q <= 1'b0;
      play_q   <= 1'b0;
      rnum_q   <= 1'b0;
      pnum_q   <= 1'b0;
      sel_q    <= 1'b0;
      valid_q  <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      dbp_q    <= db_q;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      record_q <= record_d;
      play_q   <= play_d;
      rnum_q   <= rnum_d;
      pnum_q   <= pnum_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
    end
  end

  assign record      = record_q;
  assign play        = play_q;
  assign recordNum   = rnum_q;
  assign clipPlayNum = pnum_q;
  assign clip_sel    = sel_q;
  assign clip_valid  = valid_q;

endmodule

// File: tb/tb_clip_control_input.sv
// Directed bench for clip_control_input with DEBOUNCE_CYCLES=4, MAX_REC_CYCLES=20:
// a vector table of button actions plus hand sequences for timing corner cases.
module tb_clip_control_input;

  logic       clock = 1'b0;
  logic       reset;
  logic       btn_record, btn_play, btn_clip, clip_done;
  logic       record, recordNum, play, clipPlayNum, clip_sel;
  logic [1:0] clip_valid;

  int checks = 0;
  int errors = 0;

  clip_control_input #(
    .DEBOUNCE_CYCLES(4),
    .MAX_REC_CYCLES (20)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .btn_record (btn_record),
    .btn_play   (btn_play),
    .btn_clip   (btn_clip),
    .clip_done  (clip_done),
    .record     (record),
    .recordNum  (recordNum),
    .play       (play),
    .clipPlayNum(clipPlayNum),
    .clip_sel   (clip_sel),
    .clip_valid (clip_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rec, ply, clp, done;
    int unsigned hold, gap;
    logic        e_rec, e_ply, e_rnum, e_pnum, e_sel;
    logic [1:0]  e_valid;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_all(input string n, input logic er, input logic ep, input logic ern,
                         input logic epn, input logic es, input logic [1:0] ev);
    chk({n, ".record"},      {1'b0, record},      {1'b0, er});
    chk({n, ".play"},        {1'b0, play},        {1'b0, ep});
    chk({n, ".recordNum"},   {1'b0, recordNum},   {1'b0, ern});
    chk({n, ".clipPlayNum"}, {1'b0, clipPlayNum}, {1'b0, epn});
    chk({n, ".clip_sel"},    {1'b0, clip_sel},    {1'b0, es});
    chk({n, ".clip_valid"},  clip_valid,          ev);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic p, input logic c, input logic d);
    btn_record = r;
    btn_play   = p;
    btn_clip   = c;
    clip_done  = d;
  endtask

  task automatic add(input string name, input logic r, input logic p, input logic c,
                     input logic d, input int unsigned hold, input int unsigned gap,
                     input logic er, input logic ep, input logic ern, input logic epn,
                     input logic es, input logic [1:0] ev);
    vec_t v;
    v.name = name; v.rec = r; v.ply = p; v.clp = c; v.done = d;
    v.hold = hold; v.gap = gap;
    v.e_rec = er; v.e_ply = ep; v.e_rnum = ern; v.e_pnum = epn; v.e_sel = es;
    v.e_valid = ev;
    vq.push_back(v);
  endtask

  initial begin
    // name, rec ply clp done, hold gap, exp: rec ply rnum pnum sel valid
    add("play_clip1",       0,1,0,0, 8,6, 0,1,0,0,0,2'b01);
    add("done_stop",        0,0,0,1, 1,0, 0,0,0,0,0,2'b01);
    add("clip_toggle",      0,0,1,0, 8,6, 0,0,0,0,1,2'b01);
    add("play_gated",       0,1,0,0, 8,6, 0,0,0,0,1,2'b01);
    add("rec_clip2",        1,0,0,0, 8,6, 1,0,1,0,1,2'b01);
    add("rec_stop",         1,0,0,0, 8,6, 0,0,1,0,1,2'b11);
    add("play_clip2",       0,1,0,0, 8,6, 0,1,1,1,1,2'b11);
    add("rec_clip_in_play", 1,0,1,0, 8,6, 0,1,1,1,1,2'b11);
    add("play_stop",        0,1,0,0, 8,6, 0,0,1,1,1,2'b11);
    add("done_idle",        0,0,0,1, 1,0, 0,0,1,1,1,2'b11);
    add("clip_play_sim",    0,1,1,0, 8,6, 0,1,1,1,0,2'b11);
    add("done_stop2",       0,0,0,1, 1,0, 0,0,1,1,0,2'b11);

    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick(3);
    chk_all("reset_state", 0,0,0,0,0,2'b00);
    reset = 1'b0;

    // Bounce: 3-cycle glitch, 2 low, then 10 high; record rises at edge 13
    // and auto-stops 20 cycles later with no further presses.
    btn_record = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      chk($sformatf("bounce_rec_edge%0d", k), {1'b0, record},
          {1'b0, logic'((k >= 13) && (k <= 32))});
      if (k == 3)  btn_record = 1'b0;
      if (k == 5)  btn_record = 1'b1;
      if (k == 15) btn_record = 1'b0;
    end
    chk_all("auto_stop", 0,0,0,0,0,2'b01);

    foreach (vq[i]) begin
      drive(vq[i].rec, vq[i].ply, vq[i].clp, vq[i].done);
      tick(vq[i].hold);
      chk_all(vq[i].name, vq[i].e_rec, vq[i].e_ply, vq[i].e_rnum, vq[i].e_pnum,
              vq[i].e_sel, vq[i].e_valid);
      drive(0, 0, 0, 0);
      if (vq[i].gap != 0) tick(vq[i].gap);
    end

    // Record beats play; play+clip during RECORD are lost; auto-stop still fires
    drive(1, 1, 0, 0);
    tick(8);
    chk_all("sim_rec_play", 1,0,0,1,0,2'b11);
    drive(0, 0, 0, 0);
    tick(6);
    drive(0, 1, 1, 0);
    tick(8);
    chk_all("ign_in_rec", 1,0,0,1,0,2'b11);
    drive(0, 0, 0, 0);
    tick(5);
    chk("rec_last_cycle", {1'b0, record}, 2'b01);
    tick(1);
    chk_all("auto_stop2", 0,0,0,1,0,2'b11);

    // Reset mid-RECORD
    drive(0, 0, 1, 0);
    tick(8);
    chk_all("clip_pre_reset", 0,0,0,1,1,2'b11);
    drive(0, 0, 0, 0);
    tick(6);
    drive(1, 0, 1, 0);
    tick(8);
    chk_all("rec_clip_sim", 1,0,1,1,0,2'b11);
    drive(0, 0, 0, 0);
    tick(5);
    chk("rec_cycle5", {1'b0, record}, 2'b01);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_all("reset_mid_rec", 0,0,0,0,0,2'b00);
    drive(0, 1, 0, 0);
    tick(8);
    chk_all("play_after_reset", 0,0,0,0,0,2'b00);
    drive(0, 0, 0, 0);
    tick(6);
    drive(1, 0, 0, 0);
    tick(8);
    chk_all("rec_after_reset", 1,0,0,0,0,2'b00);
    drive(0, 0, 0, 0);
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
